// File: rtl/sipo_rx.sv
// Serial-in/parallel-out deserializer: rebuilds WIDTH-bit words from a framed bit
// stream and presents them on a one-deep valid/ready output register.
module sipo_rx #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sync_i,
    input  logic             serial_i,
    input  logic             ready_i,
    input  logic             clr_ovr_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic             busy_o,
    output logic             overrun_o
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             ovr_q, ovr_d;
    logic [WIDTH-1:0] word_c;
    logic             complete_c;

    // Data-bit position that serial bit k lands in.
    function automatic logic [CW-1:0] bit_pos(input logic [CW-1:0] k);
        if (LSB_FIRST) begin
            return k;
        end
        return LAST - k;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sh_d       = sh_q;
        data_d     = data_q;
        valid_d    = valid_q;
        ovr_d      = ovr_q;
        complete_c = 1'b0;
        word_c     = sh_q;
        word_c[bit_pos(cnt_q)] = serial_i;

        if (clr_ovr_i) begin
            ovr_d = 1'b0;
        end
        if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end

        // A sync strobe always restarts the frame, even on what would be the last bit.
        case (state_q)
            IDLE: begin
                if (sync_i) begin
                    sh_d = '0;
                    sh_d[bit_pos('0)] = serial_i;
                    cnt_d   = CW'(1);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (sync_i) begin
                    sh_d = '0;
                    sh_d[bit_pos('0)] = serial_i;
                    cnt_d = CW'(1);
                end else if (cnt_q == LAST) begin
                    sh_d       = word_c;
                    cnt_d      = '0;
                    state_d    = IDLE;
                    complete_c = 1'b1;
                end else begin
                    sh_d  = word_c;
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // Commit overrides the consume; a drop sets overrun after any clear.
        if (complete_c) begin
            if (!valid_q || ready_i) begin
                data_d  = word_c;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    assign data_o    = data_q;
    assign valid_o   = valid_q;
    assign overrun_o = ovr_q;
    assign busy_o    = (state_q == SHIFT);

endmodule

// File: tb/tb_sipo_rx.sv
// Directed bench for sipo_rx: table of framed words plus hand sequences for reset,
// resync, overrun and the MSB-first build.
module tb_sipo_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sync_i = 1'b0;
    logic       serial_i = 1'b0;
    logic       ready_i = 1'b0;
    logic       clr_ovr_i = 1'b0;
    logic [7:0] data_l, data_m;
    logic       valid_l, valid_m, busy_l, busy_m, ovr_l, ovr_m;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sipo_rx #(.WIDTH(8), .LSB_FIRST(1'b1)) dut (
        .clk(clk), .rst(rst), .sync_i(sync_i), .serial_i(serial_i),
        .ready_i(ready_i), .clr_ovr_i(clr_ovr_i), .data_o(data_l),
        .valid_o(valid_l), .busy_o(busy_l), .overrun_o(ovr_l)
    );

    sipo_rx #(.WIDTH(8), .LSB_FIRST(1'b0)) dut_m (
        .clk(clk), .rst(rst), .sync_i(sync_i), .serial_i(serial_i),
        .ready_i(ready_i), .clr_ovr_i(clr_ovr_i), .data_o(data_m),
        .valid_o(valid_m), .busy_o(busy_m), .overrun_o(ovr_m)
    );

    typedef struct {
        logic [7:0] din;
        logic       rdy;
        logic       clr;
        logic       drain;
        logic [7:0] exp_data;
        logic       exp_valid;
        logic       exp_ovr;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Apply one bit across one rising edge; returns at the following falling edge.
    task automatic step(input logic s, input logic d);
        sync_i   = s;
        serial_i = d;
        @(negedge clk);
        sync_i   = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        for (int k = 0; k < 8; k++) begin
            step(k == 0, b[k]);
            if (k == 3) chk("busy_mid", 32'(busy_l), 32'd1);
        end
    endtask

    function automatic logic [7:0] rev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = b[7-i];
        return r;
    endfunction

    initial begin
        logic [7:0] g;
        logic [7:0] r;

        vecs[0] = '{8'h55, 1'b1, 1'b0, 1'b0, 8'h55, 1'b1, 1'b0};
        vecs[1] = '{8'hFF, 1'b1, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b0};
        vecs[2] = '{8'h12, 1'b1, 1'b0, 1'b0, 8'h12, 1'b1, 1'b0};
        vecs[3] = '{8'h34, 1'b1, 1'b0, 1'b0, 8'h34, 1'b1, 1'b0};
        vecs[4] = '{8'h56, 1'b1, 1'b0, 1'b1, 8'h56, 1'b1, 1'b0};
        vecs[5] = '{8'hA5, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0};
        vecs[6] = '{8'hC3, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b1};
        vecs[7] = '{8'h11, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b1};

        repeat (2) @(negedge clk);
        chk("rst_data", 32'(data_l), 32'd0);
        chk("rst_valid", 32'(valid_l), 32'd0);
        chk("rst_busy", 32'(busy_l), 32'd0);
        chk("rst_ovr", 32'(ovr_l), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Framed words back to back, then backpressure and overrun.
        foreach (vecs[i]) begin
            ready_i   = vecs[i].rdy;
            clr_ovr_i = vecs[i].clr;
            send(vecs[i].din);
            clr_ovr_i = 1'b0;
            chk($sformatf("v%0d_data", i), 32'(data_l), 32'(vecs[i].exp_data));
            chk($sformatf("v%0d_valid", i), 32'(valid_l), 32'(vecs[i].exp_valid));
            chk($sformatf("v%0d_ovr", i), 32'(ovr_l), 32'(vecs[i].exp_ovr));
            chk($sformatf("v%0d_busy", i), 32'(busy_l), 32'd0);
            if (vecs[i].drain) begin
                step(1'b0, 1'b0);
                chk($sformatf("v%0d_pulse", i), 32'(valid_l), 32'd0);
                chk($sformatf("v%0d_hold", i), 32'(data_l), 32'(vecs[i].exp_data));
            end
        end

        clr_ovr_i = 1'b1;
        step(1'b0, 1'b0);
        clr_ovr_i = 1'b0;
        chk("clr_ovr", 32'(ovr_l), 32'd0);
        chk("clr_valid_kept", 32'(valid_l), 32'd1);
        ready_i = 1'b1;
        step(1'b0, 1'b0);
        ready_i = 1'b0;
        chk("consume_valid", 32'(valid_l), 32'd0);
        chk("consume_data", 32'(data_l), 32'hA5);

        // Asynchronous reset in the middle of a frame.
        send(8'hE7);
        chk("e7_data", 32'(data_l), 32'hE7);
        g = 8'hA5;
        step(1'b1, g[0]);
        step(1'b0, g[1]);
        step(1'b0, g[2]);
        chk("pre_rst_busy", 32'(busy_l), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_data", 32'(data_l), 32'd0);
        chk("arst_valid", 32'(valid_l), 32'd0);
        chk("arst_busy", 32'(busy_l), 32'd0);
        chk("arst_ovr", 32'(ovr_l), 32'd0);
        chk("arst_data_m", 32'(data_m), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        ready_i = 1'b1;
        step(1'b0, 1'b1);
        chk("post_rst_idle", 32'(busy_l), 32'd0);
        send(8'h3C);
        chk("3c_data", 32'(data_l), 32'h3C);
        chk("3c_valid", 32'(valid_l), 32'd1);
        chk("3c_ovr", 32'(ovr_l), 32'd0);
        step(1'b0, 1'b0);

        // Resync after three garbage bits.
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        chk("garbage_valid", 32'(valid_l), 32'd0);
        send(8'h96);
        chk("96_data", 32'(data_l), 32'h96);
        chk("96_valid", 32'(valid_l), 32'd1);
        chk("96_ovr", 32'(ovr_l), 32'd0);
        step(1'b0, 1'b0);
        chk("96_pulse", 32'(valid_l), 32'd0);

        // Sync on the would-be completing edge discards the word.
        g = 8'h77;
        for (int k = 0; k < 7; k++) step(k == 0, g[k]);
        g = 8'h81;
        step(1'b1, g[0]);
        chk("late_sync_valid", 32'(valid_l), 32'd0);
        chk("late_sync_busy", 32'(busy_l), 32'd1);
        for (int k = 1; k < 8; k++) step(1'b0, g[k]);
        chk("81_data", 32'(data_l), 32'h81);
        chk("81_valid", 32'(valid_l), 32'd1);
        step(1'b0, 1'b0);

        // MSB-first build sees the same stream bit-reversed.
        send(8'hC3);
        chk("c3_data_l", 32'(data_l), 32'hC3);
        chk("c3_data_m", 32'(data_m), 32'hC3);
        send(8'h0B);
        chk("0b_data_l", 32'(data_l), 32'h0B);
        chk("0b_data_m", 32'(data_m), 32'hD0);
        r = 8'($urandom_range(0, 255));
        send(rev8(r));
        chk("rand_data_m", 32'(data_m), 32'(r));
        chk("rand_valid_m", 32'(valid_m), 32'd1);
        chk("rand_data_l", 32'(data_l), 32'(rev8(r)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
